// File: rtl/cla_unit_pkg.sv
// cla_unit_pkg: shared width constant and packed lookahead result type
package cla_unit_pkg;
  localparam int W = 4;
  typedef struct packed {
    logic [W-1:0] c;
    logic         g;
    logic         p;
  } cla_res_t;
endpackage

// File: rtl/cla_unit_if.sv
// cla_unit_if: request and result signals of the 4-position lookahead unit
interface cla_unit_if;
  logic in_valid;
  logic g0, g1, g2, g3;
  logic p0, p1, p2, p3;
  logic cin;
  logic out_valid;
  logic C1, C2, C3, C4;
  logic G, P;
  modport master (
    output in_valid, g0, g1, g2, g3, p0, p1, p2, p3, cin,
    input  out_valid, C1, C2, C3, C4, G, P
  );
  modport slave (
    input  in_valid, g0, g1, g2, g3, p0, p1, p2, p3, cin,
    output out_valid, C1, C2, C3, C4, G, P
  );
endinterface

// File: rtl/cla_logic.sv
// cla_logic: flat two-level carry lookahead equations, no clock
module cla_logic
  import cla_unit_pkg::*;
(
  input  logic [W-1:0] g_i,
  input  logic [W-1:0] p_i,
  input  logic         cin_i,
  output cla_res_t     res_o
);
  logic gg;
  // Every carry is a sum of products of the raw inputs; no carry feeds the next one
  always_comb begin
    gg = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
       | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    res_o.c[0] = g_i[0] | (p_i[0] & cin_i);
    res_o.c[1] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
    res_o.c[2] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
               | (p_i[2] & p_i[1] & p_i[0] & cin_i);
    res_o.c[3] = gg | (&p_i & cin_i);
    res_o.g    = gg;
    res_o.p    = &p_i;
  end
endmodule

// File: rtl/cla_unit.sv
// cla_unit: registered 4-position carry lookahead with one-cycle latency
module cla_unit
  import cla_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cla_unit_if.slave  bus
);
  cla_res_t comb, res_d, res_q;
  logic     vld_d, vld_q;
  cla_logic u_logic (
    .g_i   ({bus.g3, bus.g2, bus.g1, bus.g0}),
    .p_i   ({bus.p3, bus.p2, bus.p1, bus.p0}),
    .cin_i (bus.cin),
    .res_o (comb)
  );
  // Capture a new result only when qualified; otherwise keep the last one
  always_comb begin
    res_d = bus.in_valid ? comb : res_q;
    vld_d = bus.in_valid;
  end
  // Result register and valid flag, cleared synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end
  assign bus.out_valid = vld_q;
  assign bus.C1        = res_q.c[0];
  assign bus.C2        = res_q.c[1];
  assign bus.C3        = res_q.c[2];
  assign bus.C4        = res_q.c[3];
  assign bus.G         = res_q.g;
  assign bus.P         = res_q.p;
endmodule

// File: tb/tb_cla_unit.sv
// tb_cla_unit: randomized and directed checks of cla_unit against a carry-chain model
module tb_cla_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  logic [6:0] exp_q = '0;
  cla_unit_if bus ();
  cla_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [5:0] ref_res(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] cs;
    logic c, gg;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      c = g[i] | (p[i] & c);
      cs[i] = c;
    end
    gg = 1'b0;
    for (int i = 0; i < 4; i++) gg = g[i] | (p[i] & gg);
    return {cs, gg, &p};
  endfunction
  function automatic logic [6:0] obs();
    return {bus.out_valid, bus.C4, bus.C3, bus.C2, bus.C1, bus.G, bus.P};
  endfunction
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b (v,C4..C1,G,P)", tag, got, want);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [3:0] g, input logic [3:0] p,
                      input logic ci, input string tag);
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    {bus.g3, bus.g2, bus.g1, bus.g0} = g;
    {bus.p3, bus.p2, bus.p1, bus.p0} = p;
    bus.cin = ci;
    @(posedge clk);
    if (r) exp_q = '0;
    else if (v) exp_q = {1'b1, ref_res(g, p, ci)};
    else exp_q[6] = 1'b0;
    #1 check(tag, obs(), exp_q);
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b1;
    {bus.g3, bus.g2, bus.g1, bus.g0, bus.p3, bus.p2, bus.p1, bus.p0, bus.cin} = '1;
    step(1, 1, 4'b1111, 4'b1111, 1, "reset");
    check("reset_zero", obs(), 7'b0);
    step(0, 1, 4'b0110, 4'b1111, 0, "caseA");
    check("caseA_spec", obs(), 7'b1_1110_11);
    step(0, 1, 4'b0100, 4'b0111, 0, "caseB");
    check("caseB_spec", obs(), 7'b1_0100_00);
    step(0, 1, 4'b0001, 4'b1110, 0, "caseC");
    check("caseC_spec", obs(), 7'b1_1111_10);
    step(0, 1, 4'b0000, 4'b1111, 1, "caseD1");
    check("caseD1_spec", obs(), 7'b1_1111_01);
    step(0, 1, 4'b0000, 4'b1111, 0, "caseD0");
    check("caseD0_spec", obs(), 7'b1_0000_01);
    step(0, 1, 4'b0001, 4'b1110, 0, "hold_pre");
    step(0, 0, 4'b0000, 4'b0000, 1, "hold1");
    check("hold1_spec", obs(), 7'b0_1111_10);
    step(0, 0, 4'b1111, 4'b1111, 1, "hold2");
    check("hold2_spec", obs(), 7'b0_1111_10);
    step(0, 1, 4'b0110, 4'b1111, 0, "mid_pre");
    step(1, 1, 4'b0001, 4'b1110, 0, "mid_rst");
    check("mid_rst_spec", obs(), 7'b0);
    step(0, 1, 4'b0100, 4'b0111, 0, "post_rst");
    check("post_rst_spec", obs(), 7'b1_0100_00);
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kv;
      kv = 9'(k);
      step(0, 1, kv[3:0], kv[7:4], kv[8], "exh");
    end
    for (int k = 0; k < 400; k++) begin
      logic [8:0] rv;
      rv = 9'($urandom);
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), rv[3:0], rv[7:4], rv[8], "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cla_unit.md
CLA_UNIT -- requirements
Module: cla_unit

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 4 bit-positions.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  qualifies g0..g3, p0..p3 and cin in the current cycle.
REQ-005 g0, g1, g2, g3  input  1 each  bit-position generate signals; index 0 is least significant.
REQ-006 p0, p1, p2, p3  input  1 each  bit-position propagate signals.
REQ-007 cin  input  1  carry into position 0.
REQ-008 out_valid  output  1  high when C1..C4, G and P hold a result.
REQ-009 C1, C2, C3, C4  output  1 each  carries into positions 1, 2, 3 and out of position 3.
REQ-010 G, P  output  1 each  group generate and group propagate of the 4-position block.

Function
REQ-011 C1 SHALL equal g0 | p0&cin.
REQ-012 C2 SHALL equal g1 | p1&g0 | p1&p0&cin.
REQ-013 C3 SHALL equal g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&cin.
REQ-014 C4 SHALL equal g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 | p3&p2&p1&p0&cin.
REQ-015 G SHALL equal g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0; G SHALL be independent of cin.
REQ-016 P SHALL equal p0&p1&p2&p3; P SHALL be independent of cin and of every g.
REQ-017 Carries SHALL be computed in flat two-level form as listed, with no ripple from Ck to Ck+1.
REQ-018 Latency SHALL be exactly one cycle.
  - Inputs sampled at edge N with in_valid=1 appear on C1..C4, G and P after edge N.
  - out_valid SHALL be 1 in that same cycle.
REQ-019 When in_valid=0 at an edge, C1..C4, G and P SHALL hold their previous values and out_valid SHALL go to 0.
REQ-020 Back-to-back valid inputs SHALL produce one result per cycle; there is no backpressure and no stall.
REQ-021 g and p values are not checked for consistency; g=1 together with p=1 at one position is legal and uses the same equations.

Reset
REQ-022 While rst=1 at a rising edge, C1..C4, G, P and out_valid SHALL all become 0, regardless of in_valid.
REQ-023 In the first edge after rst deasserts, a valid input SHALL be captured normally; there are no extra warm-up cycles.
REQ-024 If rst is asserted mid-stream, it SHALL discard the pending result, and out_valid SHALL read 0 in the following cycle.

Structure
REQ-025 A shared package SHALL hold the width constant (4).
REQ-026 The package SHALL hold a packed type for the {C4..C1, G, P} result.
REQ-027 The combinational lookahead equations SHALL live in one sub-module, cla_logic, which has no clock.
REQ-028 cla_unit SHALL wrap cla_logic together with the input-qualified output register and the out_valid flag.

Verification
REQ-029 Case A: g3..g0=0110, p3..p0=1111, cin=0, in_valid=1 -> next cycle C1..C4=0,1,1,1, G=1, P=1, out_valid=1.
REQ-030 Case B: g3..g0=0100, p3..p0=0111, cin=0 -> C1..C4=0,0,1,0, G=0, P=0.
REQ-031 Case C: g3..g0=0001, p3..p0=1110, cin=0 -> C1..C4=1,1,1,1, G=1, P=0.
REQ-032 Case D (full propagate chain): g=0000, p=1111, cin=1 -> C1..C4=1,1,1,1, G=0, P=1.
  - Same inputs with cin=0 -> all carries 0, G=0, P=1.
REQ-033 Control and reset checks:
  - Cases A, B, C applied on consecutive cycles -> results on the three following cycles, in order.
  - Dropping in_valid -> outputs held, out_valid=0.
  - Asserting rst -> all outputs 0 at the next edge.
REQ-034 Exhaustive check: all 512 combinations of g, p and cin SHALL be compared against the REQ-011..REQ-016 equations at one-cycle latency.
